// File: rtl/data_mem_resp.sv
// Single-port data memory with fixed-latency request/response handshake.
// Loads and stores of byte/half/word with alignment and range fault checking.
module data_mem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWData,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspErr,
  output logic        busy
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;

  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [1:0]  cap_size;
  logic        cap_unsigned;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        enter_resp;
  logic        commit;

  logic        op_write;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [1:0]  op_size;
  logic        op_unsigned;

  logic [1:0]    off;
  logic [31:0]   idx_wide;
  logic [AW-1:0] idx;
  logic          fault;
  logic [31:0]   rd_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_data;
  logic [3:0]    be;
  logic [31:0]   wd_rep;

  logic [31:0] rsp_data_q;
  logic        rsp_err_q;

  assign reqReady = (state == IDLE) && !rst;
  assign busy     = (state != IDLE) && !rst;
  assign rspValid = (state == RESP) && !rst;
  assign rspData  = rst ? '0 : rsp_data_q;
  assign rspErr   = rst ? 1'b0 : rsp_err_q;

  assign accept = reqValid && reqReady;

  // With LATENCY=1 the access happens on the acceptance edge itself, so the
  // operation is taken straight from the request pins instead of the capture.
  assign op_write    = (state == IDLE) ? reqWrite    : cap_write;
  assign op_addr     = (state == IDLE) ? reqAddr     : cap_addr;
  assign op_wdata    = (state == IDLE) ? reqWData    : cap_wdata;
  assign op_size     = (state == IDLE) ? reqSize     : cap_size;
  assign op_unsigned = (state == IDLE) ? reqUnsigned : cap_unsigned;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = 4'(LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign enter_resp = (state_nx == RESP);
  assign commit     = enter_resp && !rst;

  assign off      = op_addr[1:0];
  assign idx_wide = {2'b00, op_addr[31:2]};
  assign idx      = op_addr[AW+1:2];

  always_comb begin
    fault = 1'b0;
    if (op_size == 2'b11)               fault = 1'b1;
    if (op_size == 2'b01 && off[0])     fault = 1'b1;
    if (op_size == 2'b10 && off != '0)  fault = 1'b1;
    if (idx_wide >= DEPTH_L)            fault = 1'b1;
  end

  assign rd_word = mem[idx];

  always_comb begin
    ld_byte = rd_word[{off, 3'b000} +: 8];
    ld_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
    case (op_size)
      2'b00:   ld_data = op_unsigned ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = op_unsigned ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    be     = '0;
    wd_rep = op_wdata;
    case (op_size)
      2'b00: begin
        be     = 4'b0001 << off;
        wd_rep = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        be     = op_addr[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{op_wdata[15:0]}};
      end
      2'b10:   be = '1;
      default: be = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && op_write && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (enter_resp) begin
        rsp_err_q  <= fault;
        rsp_data_q <= (fault || op_write) ? '0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_write    <= reqWrite;
      cap_addr     <= reqAddr;
      cap_wdata    <= reqWData;
      cap_size     <= reqSize;
      cap_unsigned <= reqUnsigned;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: LATENCY=2 instance under directed and
// random traffic, plus a LATENCY=1 instance under back-to-back requests.
module tb_data_mem_resp;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, reqValid, reqReady, reqWrite, reqUnsigned;
  logic        rspValid, rspErr, busy;
  logic [31:0] reqAddr, reqWData, rspData;
  logic [1:0]  reqSize;

  logic        rst1, reqValid1, reqReady1, reqWrite1, reqUnsigned1;
  logic        rspValid1, rspErr1, busy1;
  logic [31:0] reqAddr1, reqWData1, rspData1;
  logic [1:0]  reqSize1;

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u2 (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady),
    .reqWrite(reqWrite), .reqAddr(reqAddr), .reqWData(reqWData),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .rspValid(rspValid),
    .rspData(rspData), .rspErr(rspErr), .busy(busy)
  );

  data_mem_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst1), .reqValid(reqValid1), .reqReady(reqReady1),
    .reqWrite(reqWrite1), .reqAddr(reqAddr1), .reqWData(reqWData1),
    .reqSize(reqSize1), .reqUnsigned(reqUnsigned1), .rspValid(rspValid1),
    .rspData(rspData1), .rspErr(rspErr1), .busy(busy1)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref1 [8];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: byte-addressed view of the word array.
  task automatic model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un,
                       output logic [31:0] d, output logic err);
    int unsigned nb, offs, idx;
    logic [31:0] v, mask;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    offs = a % 4;
    idx  = a / 4;
    err  = (sz == 2'd3) || (offs % nb != 0) || (idx >= DEPTH);
    d    = '0;
    if (!err) begin
      if (wr) begin
        for (int k = 0; k < int'(nb); k++)
          ref_mem[idx][8*(int'(offs)+k) +: 8] = wd[8*k +: 8];
      end else begin
        v = ref_mem[idx] >> (8 * offs);
        if (nb < 4) begin
          mask = 32'((64'd1 << (8 * nb)) - 1);
          v = v & mask;
          if (!un && v[8*nb-1]) v = v | ~mask;
        end
        d = v;
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!reqReady && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, reqReady}, 32'd1);
  endtask

  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un, input logic hold);
    exp_t e;
    wait_ready();
    reqValid    = 1'b1;
    reqWrite    = wr;
    reqAddr     = a;
    reqWData    = wd;
    reqSize     = sz;
    reqUnsigned = un;
    model(wr, a, wd, sz, un, e.data, e.err);
    e.due = cyc + LAT;
    exp_q.push_back(e);
    @(negedge clk);
    if (hold) begin
      chk("busy_wait", {31'd0, busy}, 32'd1);
      chk("ready_wait_state", {31'd0, reqReady}, 32'd0);
      reqWrite = 1'b0;
      reqAddr  = 32'h14;
      reqSize  = 2'd2;
      @(negedge clk);
    end
    reqValid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rspValid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", rspData, e.data);
        chk("rsp_err", {31'd0, rspErr}, {31'd0, e.err});
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [1:0]  sz;
    int          r, n;

    rst = 1'b1;  reqValid = 1'b0;  reqWrite = 1'b0;  reqAddr = '0;
    reqWData = '0;  reqSize = '0;  reqUnsigned = 1'b0;
    rst1 = 1'b1; reqValid1 = 1'b0; reqWrite1 = 1'b0; reqAddr1 = '0;
    reqWData1 = '0; reqSize1 = '0; reqUnsigned1 = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, reqReady}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rspvalid", {31'd0, rspValid}, 32'd0);
    chk("rst_rspdata", rspData, 32'd0);
    chk("rst_rsperr", {31'd0, rspErr}, 32'd0);
    chk("rst_ready_l1", {31'd0, reqReady1}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, reqReady}, 32'd1);

    for (int w = 0; w < 16; w++) issue(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, 1'b0);

    issue(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);
    issue(1'b1, 32'h11, 32'h80, 2'd0, 1'b0, 1'b0);
    issue(1'b0, 32'h11, 32'h0, 2'd0, 1'b0, 1'b0);
    issue(1'b0, 32'h11, 32'h0, 2'd0, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);
    issue(1'b0, 32'h13, 32'h0, 2'd1, 1'b0, 1'b0);
    issue(1'b0, 32'h12, 32'h0, 2'd2, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 2'd3, 1'b0, 1'b0);
    issue(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);
    issue(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 2'd2, 1'b0, 1'b1);
    issue(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);

    // Reset during WAIT of a store: transaction aborts, memory untouched.
    wait_ready();
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h20;
    reqWData = 32'h12345678; reqSize = 2'd2; reqUnsigned = 1'b0;
    @(negedge clk);
    reqValid = 1'b0;
    chk("abort_in_wait", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_rst_ready", {31'd0, reqReady}, 32'd0);
    chk("abort_rst_valid", {31'd0, rspValid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", {31'd0, reqReady}, 32'd1);
    issue(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 7));
      else             a = 32'($urandom_range(0, 63));
      sz = 2'($urandom_range(0, 3));
      wd = $urandom;
      issue(1'($urandom_range(0, 1)), a, wd, sz, 1'($urandom_range(0, 1)), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);

    // LATENCY=1 instance: reqValid held high, accepts alternate cycles.
    @(negedge clk);
    rst1 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        reqValid1 = 1'b1;
        reqWrite1 = (i < 16);
        reqAddr1  = 32'(((i % 16) / 2) * 4);
        reqSize1  = 2'd2;
        if (i < 16) begin
          wd = $urandom;
          reqWData1 = wd;
          ref1[(i % 16) / 2] = wd;
        end
      end
      #1;
      chk("l1_ready", {31'd0, reqReady1}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("l1_rspvalid", {31'd0, rspValid1}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i % 2 == 1) begin
        chk("l1_rspdata", rspData1, (i < 16) ? 32'd0 : ref1[(i % 16) / 2]);
        chk("l1_rsperr", {31'd0, rspErr1}, 32'd0);
      end
      @(negedge clk);
    end
    reqValid1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit words in the data array (power of two).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 reqValid  in  1  request present.
REQ-007 reqReady  out  1  block can accept a request this cycle.
REQ-008 reqWrite  in  1  1 = store, 0 = load.
REQ-009 reqAddr  in  32  byte address.
REQ-010 reqWData  in  32  store data, right-aligned.
REQ-011 reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-012 reqUnsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-013 rspValid  out  1  one-cycle response pulse.
REQ-014 rspData  out  32  load result, right-aligned and extended.
REQ-015 rspErr  out  1  request faulted; qualified by rspValid.
REQ-016 busy  out  1  transaction in flight (state not IDLE).

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-018 reqReady SHALL be 1 only in IDLE.
REQ-019 A request is accepted on the rising edge where reqValid=1 and reqReady=1; all req* inputs are captured on that edge.
REQ-020 On acceptance: go to RESP if LATENCY=1, else go to WAIT with the down-counter loaded to LATENCY-2.
REQ-021 In WAIT, decrement the counter each cycle and go to RESP on the cycle the counter reaches 0.
REQ-022 In RESP, rspValid SHALL be 1 for exactly one cycle, then return to IDLE; rspValid is asserted exactly LATENCY cycles after the acceptance edge.
REQ-023 reqValid while not IDLE is ignored; there is no queuing, so sustained throughput is one request per LATENCY+1 cycles.
REQ-024 Fault condition: reqSize=11; half with addr[0]=1; word with addr[1:0]!=00; or addr[31:2] >= DEPTH_WORDS.
REQ-025 A faulted request SHALL give rspErr=1 and rspData=0, and memory SHALL NOT be modified.
REQ-026 A store SHALL write only the addressed byte lanes: byte lane addr[1:0]; half lanes addr[1]*2 and addr[1]*2+1; word all four lanes.
REQ-027 Store data comes from reqWData[7:0], [15:0] or [31:0] respectively, and is placed in the addressed lanes.
REQ-028 A store SHALL commit on the edge entering RESP; its response SHALL have rspData=0 and rspErr=0.
REQ-029 A load SHALL read the word at the edge entering RESP, select the addressed lanes, and extend to 32 bits per reqUnsigned (word loads are unaffected).
REQ-030 rspData and rspErr SHALL hold their values until the next response and SHALL be 0 after reset.
REQ-031 Address bits above the array index are checked only by REQ-024; there is no wrap-around.

Reset
REQ-032 While rst=1: state=IDLE, counter=0, rspValid=0, rspData=0, rspErr=0, busy=0, reqReady=0.
REQ-033 reqReady SHALL rise on the first cycle after rst deasserts.
REQ-034 Reset in WAIT or RESP SHALL abort the transaction with no rspValid pulse.
REQ-035 Reset asserted in WAIT SHALL cause no memory write; a store already committed on entry to RESP SHALL persist.
REQ-036 Memory contents are not reset.

Verification
REQ-037 LATENCY=2: word store 0xDEADBEEF to 0x10, then word load from 0x10 -> rspValid 2 cycles after each accept, rspData=0xDEADBEEF, rspErr=0.
REQ-038 Byte store 0x80 to 0x11, then a signed byte load and an unsigned byte load from 0x11 -> 0xFFFFFF80 and 0x00000080; a word load from 0x10 -> 0xDEAD80EF.
REQ-039 Half load from 0x13, word load from 0x12, and size=11 -> rspErr=1, rspData=0; a word load from 0x10 afterwards is unchanged.
REQ-040 Word store to 4*DEPTH_WORDS -> rspErr=1 and no memory change; reqValid held high during WAIT -> ignored, busy=1, reqReady=0.
REQ-041 Assert rst in the WAIT cycle of a store of 0x12345678 to 0x20 -> no rspValid, reqReady=1 on the cycle after rst drops, and a word load from 0x20 returns the prior contents.
REQ-042 LATENCY=1: back-to-back reqValid -> accepts every 2 cycles, each rspValid 1 cycle after its accept.
